// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 master and its watchdog.
package apb4_pkg;

  localparam int PKG_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = PKG_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb4_master_wdt.sv
// ACCESS-phase watchdog: counts wait cycles since the last clear and flags
// the wait cycle whose increment reaches the limit. A limit of 0 never fires.
module apb4_master_wdt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit ARMED = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(LAST);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (ARMED && enable && (count_q < LIMIT_CNT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = ARMED && enable && (count_q == LAST_CNT);

endmodule

// File: rtl/apb4_master.sv
// APB4 master: takes one command at a time, runs SETUP/ACCESS on the bus and
// holds the slave response until consumed; a watchdog bounds ACCESS stretching.
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | PSEL high, PENABLE low, one cycle
//   ACCESS | PSEL and PENABLE high until PREADY or watchdog expiry
//   RESP   | rsp_valid high until rsp_ready
module apb4_master
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = PKG_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  apb_state_e state_q, state_d;

  logic                    cmd_ready_d, psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_d, rsp_rdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_d;
  logic [2:0]              pprot_d;
  logic                    rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
  logic                    accept, wdt_enable, wdt_expired;

  assign accept     = (state_q == IDLE) && cmd_valid && cmd_ready;
  assign wdt_enable = (state_q == ACCESS) && !PREADY;

  apb4_master_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk_sys (PCLK),
    .rst_n   (PRESETn),
    .clear   (accept),
    .enable  (wdt_enable),
    .expired (wdt_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    pprot_d       = PPROT;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_slverr_d  = rsp_slverr;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pprot_d   = cmd_prot;
          // Reads never expose write data or strobes on the bus.
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_slverr_d  = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (wdt_expired) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so cmd_ready stays low through reset and rises one edge later.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_ready   <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready   <= cmd_ready_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      PPROT       <= pprot_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_slverr  <= rsp_slverr_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master: a transfer-timeline model predicts every
// output on every cycle, plus literal expectations per directed transfer.
module tb_apb4_master;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata, PRDATA;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        PREADY, PSLVERR;

  logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  apb4_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;

  // Timeline model: k counts edges since the accepting edge, -1 when idle.
  bit          chk_on = 1'b0;
  int          k = -1;
  bit          t_wr, t_serr, t_to;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_strb;
  logic [2:0]  t_prot;
  int          t_nacc = 0, t_last = 0, t_waits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit m_idle, m_setup, m_access, m_resp;

  always @(negedge PCLK) begin
    if (chk_on) begin
      m_setup  = (k == 0);
      m_access = (k >= 1) && (k <= t_nacc);
      m_resp   = (k > t_nacc) && (k <= t_last);
      m_idle   = !(m_setup || m_access || m_resp);
      chk("psel",      32'(PSEL),      32'(m_setup || m_access));
      chk("penable",   32'(PENABLE),   32'(m_access));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_idle));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      if (m_setup || m_access) begin
        chk("paddr",  PADDR,          t_addr);
        chk("pwrite", 32'(PWRITE),    32'(t_wr));
        chk("pprot",  32'(PPROT),     32'(t_prot));
        chk("pwdata", PWDATA,         t_wr ? t_wdata : 32'h0);
        chk("pstrb",  32'(PSTRB),     t_wr ? 32'(t_strb) : 32'h0);
      end
      if (m_resp) begin
        chk("rsp_rdata",   rsp_rdata,         (t_wr || t_to) ? 32'h0 : t_rdata);
        chk("rsp_slverr",  32'(rsp_slverr),   32'(t_to || t_serr));
        chk("rsp_timeout", 32'(rsp_timeout),  32'(t_to));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_psel"},        32'(PSEL),        32'h0);
    chk({tag, "_penable"},     32'(PENABLE),     32'h0);
    chk({tag, "_pwrite"},      32'(PWRITE),      32'h0);
    chk({tag, "_paddr"},       PADDR,            32'h0);
    chk({tag, "_pwdata"},      PWDATA,           32'h0);
    chk({tag, "_pstrb"},       32'(PSTRB),       32'h0);
    chk({tag, "_pprot"},       32'(PPROT),       32'h0);
    chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'h0);
    chk({tag, "_rsp_rdata"},   rsp_rdata,        32'h0);
    chk({tag, "_rsp_slverr"},  32'(rsp_slverr),  32'h0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'h0);
    chk({tag, "_cmd_ready"},   32'(cmd_ready),   32'h0);
  endtask

  // Slave and consumer behaviour for timeline step kk; inputs are junk wherever
  // the master must ignore them.
  task automatic drive_inputs(input int kk);
    rsp_ready = 1'b0;
    if (kk == 0) begin
      PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = $urandom;
    end else if (kk <= t_nacc) begin
      if (!t_to && kk == t_waits + 1) begin
        PREADY = 1'b1; PSLVERR = t_serr; PRDATA = t_rdata;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = $urandom;
      end
    end else begin
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      rsp_ready = (kk == t_last);
    end
  endtask

  task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                         input int waits, input bit serr, input logic [31:0] rdata,
                         input int rdelay, input int rst_k,
                         input int lit_pen, input int lit_first, input logic [31:0] lit_rdata,
                         input bit lit_serr, input bit lit_to);
    bit          acc;
    int          n_pen, first_rv;
    logic [31:0] c_rdata;
    logic        c_serr, c_to;
    t_wr = wr; t_addr = addr; t_wdata = wdata; t_strb = strb; t_prot = prot;
    t_serr = serr; t_rdata = rdata; t_waits = waits;
    t_to   = (TO != 0) && (waits >= TO);
    t_nacc = t_to ? TO : waits + 1;
    t_last = t_nacc + 1 + rdelay;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_strb = strb; cmd_prot = prot;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      acc = (cmd_ready === 1'b1);
      @(posedge PCLK); #1;
    end
    chk({name, "_accept"}, 32'(acc), 32'h1);
    if (!acc) begin
      cmd_valid = 1'b0;
      return;
    end

    k = 0;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
    drive_inputs(0);
    n_pen = 0; first_rv = -1; c_rdata = '0; c_serr = 1'b0; c_to = 1'b0;
    while (k <= t_last) begin
      @(posedge PCLK); #1;
      k++;
      if (PENABLE === 1'b1) n_pen++;
      if (rsp_valid === 1'b1 && first_rv < 0) begin
        first_rv = k; c_rdata = rsp_rdata; c_serr = rsp_slverr; c_to = rsp_timeout;
      end
      if (k == rst_k) begin
        chk_on = 1'b0;
        PRESETn = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; rsp_ready = 1'b0;
        #1;
        check_all_zero({name, "_rst"});
        repeat (3) begin
          @(posedge PCLK); #1;
          chk({name, "_rst_rsp_valid"}, 32'(rsp_valid), 32'h0);
          chk({name, "_rst_psel"},      32'(PSEL),      32'h0);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk({name, "_rel_cmd_ready"}, 32'(cmd_ready), 32'h0);
        @(posedge PCLK); #1;
        chk({name, "_rel_cmd_ready_up"}, 32'(cmd_ready), 32'h1);
        chk({name, "_rel_rsp_valid"},    32'(rsp_valid), 32'h0);
        k = -1;
        chk_on = 1'b1;
        return;
      end
      if (k <= t_last) drive_inputs(k);
    end
    k = -1;
    PREADY = 1'b0; PSLVERR = 1'b0; rsp_ready = 1'b0;

    chk({name, "_access_cycles"}, 32'(n_pen),    32'(lit_pen));
    chk({name, "_rsp_edge"},      32'(first_rv), 32'(lit_first));
    chk({name, "_rdata"},         c_rdata,       lit_rdata);
    chk({name, "_slverr"},        32'(c_serr),   32'(lit_serr));
    chk({name, "_timeout"},       32'(c_to),     32'(lit_to));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #2 PRESETn = 1'b0;
    #1 check_all_zero("por");
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1 chk("por_cmd_ready_low", 32'(cmd_ready), 32'h0);
    @(posedge PCLK); #1;
    chk("por_cmd_ready_high", 32'(cmd_ready), 32'h1);
    k = -1;
    chk_on = 1'b1;

    //      name        wr    addr          wdata         strb     prot    W  serr  rdata         D  rst pen 1st lit_rdata     serr  to
    run_txn("wr_basic", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,   3'b000, 0, 1'b0, 32'h0,        0, -1, 1,  2, 32'h0,        1'b0, 1'b0);
    run_txn("rd_wait2", 1'b0, 32'h0000_0020, 32'h1111_1111, 4'hF,   3'b010, 2, 1'b0, 32'h1234_5678, 0, -1, 3,  4, 32'h1234_5678, 1'b0, 1'b0);
    run_txn("rd_serr",  1'b0, 32'h0000_0030, 32'h0,         4'h0,   3'b001, 1, 1'b1, 32'hA5A5_0001, 0, -1, 2,  3, 32'hA5A5_0001, 1'b1, 1'b0);
    run_txn("rd_tmo",   1'b0, 32'h0000_0040, 32'h0,         4'h0,   3'b000, 4, 1'b0, 32'hFFFF_0000, 0, -1, 4,  5, 32'h0,        1'b1, 1'b1);
    run_txn("rd_edge",  1'b0, 32'h0000_0044, 32'h0,         4'h0,   3'b100, 3, 1'b0, 32'hCAFE_F00D, 0, -1, 4,  5, 32'hCAFE_F00D, 1'b0, 1'b0);
    run_txn("wr_hold",  1'b1, 32'h0000_0050, 32'h0102_0304, 4'b0101, 3'b101, 1, 1'b0, 32'h0,        5, -1, 2,  3, 32'h0,        1'b0, 1'b0);
    run_txn("wr_tmo",   1'b1, 32'h0000_0060, 32'h7777_8888, 4'b1100, 3'b011, 9, 1'b0, 32'h0,        0, -1, 4,  5, 32'h0,        1'b1, 1'b1);
    run_txn("rd_b2b",   1'b0, 32'h0000_0064, 32'h0,         4'hF,   3'b000, 0, 1'b0, 32'h0BAD_F00D, 0, -1, 1,  2, 32'h0BAD_F00D, 1'b0, 1'b0);
    run_txn("wr_rst",   1'b1, 32'h0000_0070, 32'h9999_AAAA, 4'hF,   3'b111, 3, 1'b0, 32'h0,        0,  2, 0,  0, 32'h0,        1'b0, 1'b0);
    run_txn("rd_after", 1'b0, 32'h0000_0080, 32'h0,         4'h0,   3'b000, 0, 1'b0, 32'h5555_AAAA, 0, -1, 1,  2, 32'h5555_AAAA, 1'b0, 1'b0);

    repeat (3) @(posedge PCLK);
    #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
